// File: rtl/prog_stream_loader.sv
// rtl/prog_stream_loader.sv - stream-fed instruction memory loader
//
// Purpose:
//   Accepts program words over a valid/ready stream and writes them into an
//   instruction memory starting at a programmable base address. Tracks the
//   number of accepted words, a modular checksum, and flags overflow when the
//   stream runs past the top address without an in_last marker.
//
// Ports:
//   clock, reset      - rising-edge clock, asynchronous active-high reset
//   start_load        - one-cycle start request (IDLE/DONE/ERROR only)
//   base_addr         - first write address, latched on an accepted start
//   in_valid, in_data, in_last, in_ready - program word stream
//   mem_addr, mem_write_data, mem_write  - registered memory write port
//   busy              - high while loading or zero filling
//   load_complete     - sticky success flag
//   load_error        - sticky overflow flag
//   word_count        - stream words accepted in this load
//   checksum          - sum of accepted words modulo 2**DATA_WIDTH
//
// Configuration:
//   LOADER_ZERO_FILL_EN - when defined, the addresses above the last loaded
//                         word are zeroed before load_complete is raised.

module prog_stream_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_load,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write,
  output logic                  busy,
  output logic                  load_complete,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [DATA_WIDTH-1:0] checksum
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FILL,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_TOP = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   WC_ONE   = (ADDR_WIDTH + 1)'(1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_write_data_q, mem_write_data_d;
  logic                    mem_write_q, mem_write_d;
  logic                    load_complete_q, load_complete_d;
  logic                    load_error_q, load_error_d;
  logic [ADDR_WIDTH:0]     word_count_q, word_count_d;
  logic [DATA_WIDTH-1:0]   checksum_q, checksum_d;

  logic beat_accept;
  logic ptr_at_top;

  // Ready is purely a function of state so the source sees it in the cycle
  // right after the start edge and can stream back-to-back without bubbles.
  assign in_ready    = (state_q == ST_LOAD);
  assign busy        = (state_q == ST_LOAD) || (state_q == ST_FILL);
  assign beat_accept = in_valid && in_ready;
  assign ptr_at_top  = (ptr_q == ADDR_TOP);

  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_write_data_q;
  assign mem_write      = mem_write_q;
  assign load_complete  = load_complete_q;
  assign load_error     = load_error_q;
  assign word_count     = word_count_q;
  assign checksum       = checksum_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      ptr_q            <= '0;
      mem_addr_q       <= '0;
      mem_write_data_q <= '0;
      mem_write_q      <= 1'b0;
      load_complete_q  <= 1'b0;
      load_error_q     <= 1'b0;
      word_count_q     <= '0;
      checksum_q       <= '0;
    end else begin
      state_q          <= state_d;
      ptr_q            <= ptr_d;
      mem_addr_q       <= mem_addr_d;
      mem_write_data_q <= mem_write_data_d;
      mem_write_q      <= mem_write_d;
      load_complete_q  <= load_complete_d;
      load_error_q     <= load_error_d;
      word_count_q     <= word_count_d;
      checksum_q       <= checksum_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    mem_addr_d       = mem_addr_q;
    mem_write_data_d = mem_write_data_q;
    mem_write_d      = 1'b0;
    load_complete_d  = load_complete_q;
    load_error_d     = load_error_q;
    word_count_d     = word_count_q;
    checksum_d       = checksum_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        // The sticky flags are raised from the resting state rather than on
        // the final write, so they appear one cycle after the last strobe,
        // exactly when mem_write falls.
        if (state_q == ST_DONE) begin
          load_complete_d = 1'b1;
        end
        if (state_q == ST_ERROR) begin
          load_error_d = 1'b1;
        end
        if (start_load) begin
          ptr_d           = base_addr;
          word_count_d    = '0;
          checksum_d      = '0;
          load_complete_d = 1'b0;
          load_error_d    = 1'b0;
          state_d         = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (beat_accept) begin
          mem_write_d      = 1'b1;
          mem_addr_d       = ptr_q;
          mem_write_data_d = in_data;
          word_count_d     = word_count_q + WC_ONE;
          checksum_d       = checksum_q + in_data;
          if (ptr_at_top) begin
            // The pointer never wraps: a word landing on the top address
            // either ends the load cleanly or is an overflow.
            if (in_last) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_ERROR;
            end
          end else begin
            ptr_d = ptr_q + ADDR_ONE;
            if (in_last) begin
`ifdef LOADER_ZERO_FILL_EN
              state_d = ST_FILL;
`else
              state_d = ST_DONE;
`endif
            end
          end
        end
      end

      ST_FILL: begin
`ifdef LOADER_ZERO_FILL_EN
        // Zero one address per cycle, starting just above the last loaded
        // word, so stale code from a previous longer image cannot run.
        mem_write_d      = 1'b1;
        mem_addr_d       = ptr_q;
        mem_write_data_d = '0;
        if (ptr_at_top) begin
          state_d = ST_DONE;
        end else begin
          ptr_d = ptr_q + ADDR_ONE;
        end
`else
        state_d = ST_IDLE;
`endif
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_prog_stream_loader.sv
// tb/tb_prog_stream_loader.sv - randomized self-checking bench for prog_stream_loader

module tb_prog_stream_loader;

  localparam int DW    = 16;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          start_load;
  logic [AW-1:0] base_addr;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_write_data;
  logic          mem_write;
  logic          busy;
  logic          load_complete;
  logic          load_error;
  logic [AW:0]   word_count;
  logic [DW-1:0] checksum;

  int checks = 0;
  int errors = 0;
  bit fill_en;

  logic [DW-1:0] stim_w [64];
  int wr_addr_log [$];
  int wr_data_log [$];

  always #5 clock = ~clock;

  prog_stream_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock          (clock),
    .reset          (reset),
    .start_load     (start_load),
    .base_addr      (base_addr),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_last        (in_last),
    .in_ready       (in_ready),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .busy           (busy),
    .load_complete  (load_complete),
    .load_error     (load_error),
    .word_count     (word_count),
    .checksum       (checksum)
  );

  // Instruction memory side: every strobe that reaches a commit edge is logged.
  always @(posedge clock) begin
    if (mem_write) begin
      wr_addr_log.push_back(int'(mem_addr));
      wr_data_log.push_back(int'(mem_write_data));
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_mem_write"}, 32'(mem_write), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_data"}, 32'(mem_write_data), 0);
    chk({tag, "_complete"}, 32'(load_complete), 0);
    chk({tag, "_error"}, 32'(load_error), 0);
    chk({tag, "_word_count"}, 32'(word_count), 0);
    chk({tag, "_checksum"}, 32'(checksum), 0);
  endtask

  // One complete load. last_idx < 0 means no in_last is ever offered.
  // gap_pct < 0 selects a strict 1,0,1,0 valid pattern.
  task automatic run_load(input int b, input int last_idx, input int gap_pct, input bit poke_start);
    int  cap, consumed, fill_cnt, exp_sum, sent, cycles, waited, log0, nwr, exp_addr, exp_data;
    bit  ok, acc, prev_mw, done;
    cap = DEPTH - b;
    if (last_idx >= 0 && last_idx + 1 <= cap) begin
      ok = 1'b1;
      consumed = last_idx + 1;
    end else begin
      ok = 1'b0;
      consumed = cap;
    end
    fill_cnt = (ok && fill_en) ? (cap - consumed) : 0;
    exp_sum = 0;
    for (int i = 0; i < consumed; i++) exp_sum = (exp_sum + int'(stim_w[i])) % 65536;
    log0 = wr_addr_log.size();

    base_addr  = AW'(b);
    start_load = 1'b1;
    tick;
    start_load = 1'b0;
    chk("ready_after_start", 32'(in_ready), 1);
    chk("busy_in_load", 32'(busy), 1);
    chk("count_cleared", 32'(word_count), 0);
    chk("flags_cleared", 32'({load_complete, load_error}), 0);

    sent = 0;
    cycles = 0;
    while (sent < consumed && cycles < 4000) begin
      if (gap_pct < 0) in_valid = (cycles % 2 == 0);
      else             in_valid = ($urandom_range(99) >= gap_pct);
      in_data = stim_w[sent];
      in_last = (sent == last_idx);
      if (poke_start && sent == 1) begin
        start_load = 1'b1;
        base_addr  = AW'(b ^ 3);
      end
      acc = in_valid && in_ready;
      tick;
      start_load = 1'b0;
      if (acc) sent++;
      cycles++;
    end
    chk("beats_accepted", sent, consumed);
    if (gap_pct == 0) chk("no_bubbles", cycles, consumed);

    // On overflow keep offering the next word: it must not be taken.
    if (!ok) begin
      in_valid = 1'b1;
      in_data  = stim_w[consumed];
      in_last  = 1'b0;
    end else begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end

    waited = 0;
    done = 1'b0;
    prev_mw = 1'b0;
    while (!done && waited < 200) begin
      prev_mw = mem_write;
      tick;
      waited++;
      done = load_complete || load_error;
    end
    chk("end_latency", waited, fill_cnt + 1);
    chk("write_before_flag", 32'(prev_mw), 1);
    chk("write_drops_with_flag", 32'(mem_write), 0);
    chk("load_complete", 32'(load_complete), 32'(ok));
    chk("load_error", 32'(load_error), 32'(!ok));
    chk("busy_after", 32'(busy), 0);
    chk("ready_after", 32'(in_ready), 0);
    chk("word_count", 32'(word_count), consumed);
    chk("checksum", 32'(checksum), exp_sum);

    if (!ok) begin
      repeat (3) tick;
      chk("overflow_ready_low", 32'(in_ready), 0);
      chk("overflow_count_held", 32'(word_count), consumed);
      chk("overflow_no_write", 32'(mem_write), 0);
      in_valid = 1'b0;
    end

    nwr = wr_addr_log.size() - log0;
    chk("write_total", nwr, consumed + fill_cnt);
    for (int i = 0; i < nwr && i < consumed + fill_cnt; i++) begin
      exp_addr = b + i;
      exp_data = (i < consumed) ? int'(stim_w[i]) : 0;
      chk($sformatf("wr_addr[%0d]", i), wr_addr_log[log0 + i], exp_addr);
      chk($sformatf("wr_data[%0d]", i), wr_data_log[log0 + i], exp_data);
    end
  endtask

  initial begin
    int b, cap, k, lim, sent;
`ifdef LOADER_ZERO_FILL_EN
    fill_en = 1'b1;
`else
    fill_en = 1'b0;
`endif
    reset      = 1'b1;
    start_load = 1'b0;
    base_addr  = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_last    = 1'b0;
    #12;
    check_all_zero("reset");
    reset = 1'b0;
    tick;

    // Basic load
    stim_w[0] = 16'h1111; stim_w[1] = 16'h2222; stim_w[2] = 16'h3333;
    run_load(0, 2, 0, 1'b0);

    // Backpressure with 1,0,1,0 valid and a start pulse mid-load
    for (int i = 0; i < 6; i++) stim_w[i] = DW'($urandom);
    run_load(4, 5, -1, 1'b1);

    // Exact fit at the top of memory
    for (int i = 0; i < 4; i++) stim_w[i] = DW'($urandom);
    run_load(28, 3, 0, 1'b0);

    // Overflow: three words offered from base 30, no in_last
    for (int i = 0; i < 3; i++) stim_w[i] = DW'($urandom);
    run_load(30, -1, 0, 1'b0);

    // Checksum wrap
    stim_w[0] = 16'hFFFF; stim_w[1] = 16'h0002;
    run_load(7, 1, 0, 1'b0);
    chk("checksum_wrap", 32'(checksum), 32'h0001);

    // Reset mid-load after two of five words
    for (int i = 0; i < 5; i++) stim_w[i] = DW'($urandom);
    base_addr  = AW'(3);
    start_load = 1'b1;
    tick;
    start_load = 1'b0;
    sent = 0;
    for (int c = 0; c < 20 && sent < 2; c++) begin
      in_valid = 1'b1;
      in_data  = stim_w[sent];
      in_last  = 1'b0;
      if (in_ready) sent++;
      tick;
    end
    chk("pre_reset_count", 32'(word_count), 2);
    reset = 1'b1;
    #1;
    check_all_zero("mid_reset");
    in_valid = 1'b0;
    tick;
    reset = 1'b0;
    tick;
    for (int i = 0; i < 5; i++) stim_w[i] = DW'($urandom);
    run_load(10, 4, 0, 1'b0);

    // Randomized loads
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(3) == 0) begin
        b = $urandom_range(31, 26);
        cap = DEPTH - b;
        for (int i = 0; i <= cap; i++) stim_w[i] = DW'($urandom);
        run_load(b, -1, $urandom_range(60), 1'($urandom_range(1)));
      end else begin
        b = $urandom_range(31);
        cap = DEPTH - b;
        lim = (cap < 8) ? cap : 8;
        k = $urandom_range(lim - 1);
        for (int i = 0; i <= k; i++) stim_w[i] = DW'($urandom);
        run_load(b, k, $urandom_range(60), 1'($urandom_range(1)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
